// File: rtl/drap_mem_align.sv
// Byte-addressed core access to word-addressed memory: lane enables, store data
// replication, load lane extraction with sign/zero extension, and misalignment rejection.
module drap_mem_align #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic [1:0]    size,
    input  logic          sgn,
    input  logic [AW-1:0] baddr,
    input  logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done,
    output logic          misalign,
    output logic [DW-1:0] rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-3:0] mem_waddr,
    output logic [3:0]    mem_be,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

    state_t        state_reg, state_next;
    logic          we_reg;
    logic          sgn_reg;
    logic [1:0]    size_reg;
    logic [1:0]    off_reg;
    logic [AW-3:0] waddr_reg;
    logic [3:0]    be_reg;
    logic [DW-1:0] wdata_reg;
    logic [DW-1:0] rdata_reg;

    logic          bad_align;
    logic [3:0]    be_new;
    logic [DW-1:0] wdata_rep;
    logic [7:0]    load_byte;
    logic [15:0]   load_half;
    logic [DW-1:0] load_ext;

    always_comb begin
        bad_align = 1'b0;
        be_new    = 4'b1111;
        case (size)
            2'b00: be_new = 4'b0001 << baddr[1:0];
            2'b01: begin
                bad_align = baddr[0];
                be_new    = 4'b0011 << baddr[1:0];
            end
            2'b10: bad_align = |baddr[1:0];
            default: bad_align = 1'b1;
        endcase
    end

    // Each lane carries the byte that belongs there whatever the offset, so the
    // enables alone select what memory actually writes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign wdata_rep[8*gi +: 8] = (size == 2'b00) ? wdata[7:0] :
                                          (size == 2'b01) ? wdata[8*(gi%2) +: 8] :
                                                            wdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        load_byte = 8'h00;
        case (off_reg)
            2'b00: load_byte = mem_rdata[7:0];
            2'b01: load_byte = mem_rdata[15:8];
            2'b10: load_byte = mem_rdata[23:16];
            default: load_byte = mem_rdata[31:24];
        endcase
        load_half = off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_ext  = mem_rdata;
        if (size_reg == 2'b00)
            load_ext = sgn_reg ? {{24{load_byte[7]}}, load_byte} : {24'h000000, load_byte};
        else if (size_reg == 2'b01)
            load_ext = sgn_reg ? {{16{load_half[15]}}, load_half} : {16'h0000, load_half};
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req) state_next = bad_align ? ERR : ACCESS;
            ACCESS:  if (mem_ack) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            we_reg    <= 1'b0;
            sgn_reg   <= 1'b0;
            size_reg  <= 2'b00;
            off_reg   <= 2'b00;
            waddr_reg <= '0;
            be_reg    <= 4'b0000;
            wdata_reg <= '0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && req) begin
                we_reg   <= we;
                sgn_reg  <= sgn;
                size_reg <= size;
                off_reg  <= baddr[1:0];
                // Rejected requests leave the memory-side outputs untouched.
                if (!bad_align) begin
                    waddr_reg <= baddr[AW-1:2];
                    be_reg    <= be_new;
                    wdata_reg <= wdata_rep;
                end
            end
            if (state_reg == ACCESS && mem_ack && !we_reg)
                rdata_reg <= load_ext;
        end
    end

    assign busy      = (state_reg != IDLE);
    assign mem_req   = (state_reg == ACCESS);
    assign mem_we    = (state_reg == ACCESS) && we_reg;
    assign done      = (state_reg == RESP) || (state_reg == ERR);
    assign misalign  = (state_reg == ERR);
    assign mem_waddr = waddr_reg;
    assign mem_be    = be_reg;
    assign mem_wdata = wdata_reg;
    assign rdata     = rdata_reg;

endmodule

// File: tb/tb_drap_mem_align.sv
// Directed bench for drap_mem_align: drives core accesses, plays the memory side
// with configurable wait states, and checks hand-computed results.
module tb_drap_mem_align;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sgn = 1'b0;
    logic [31:0] baddr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy, done, misalign, mem_req, mem_we;
    logic [31:0] rdata, mem_wdata;
    logic [29:0] mem_waddr;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;

    int errors = 0;
    int checks = 0;

    int          obs_req_cycles, obs_done_cycles, obs_mis_cycles, obs_done_at;
    logic        obs_we, obs_unstable, obs_overlap, obs_busy_after, obs_timeout;
    logic [29:0] obs_waddr;
    logic [3:0]  obs_be;
    logic [31:0] obs_wdata, obs_rdata;

    always #5 clk = ~clk;

    drap_mem_align #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sgn(sgn),
        .baddr(baddr), .wdata(wdata), .busy(busy), .done(done), .misalign(misalign),
        .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_waddr(mem_waddr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    // One access from issue to one cycle past done; acks after `waits` extra mem_req cycles.
    task automatic run_access(input logic w, input logic [1:0] sz, input logic s,
                              input logic [31:0] a, input logic [31:0] d,
                              input int waits, input logic [31:0] rd, input logic inject);
        obs_req_cycles = 0; obs_done_cycles = 0; obs_mis_cycles = 0; obs_done_at = 0;
        obs_we = 0; obs_unstable = 0; obs_overlap = 0; obs_busy_after = 0; obs_timeout = 0;
        obs_waddr = '0; obs_be = '0; obs_wdata = '0; obs_rdata = '0;
        @(negedge clk);
        req = 1'b1; we = w; size = sz; sgn = s; baddr = a; wdata = d; mem_ack = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            req = 1'b0;
            mem_ack = 1'b0;
            if (inject && c == 1) begin
                req = 1'b1;
                baddr = a + 32'h40;
            end
            if (mem_req) begin
                obs_req_cycles++;
                if (obs_req_cycles == 1) begin
                    obs_waddr = mem_waddr; obs_be = mem_be; obs_we = mem_we; obs_wdata = mem_wdata;
                end else if (mem_waddr !== obs_waddr || mem_be !== obs_be || mem_wdata !== obs_wdata) begin
                    obs_unstable = 1'b1;
                end
                if (obs_req_cycles == waits + 1) begin
                    mem_ack = 1'b1;
                    mem_rdata = rd;
                end
            end
            if (mem_req && (done || misalign)) obs_overlap = 1'b1;
            if (misalign) obs_mis_cycles++;
            if (done) begin
                obs_done_cycles++;
                if (obs_done_at == 0) begin
                    obs_done_at = c;
                    obs_rdata = rdata;
                end
            end
            if (obs_done_at != 0 && c == obs_done_at + 1) begin
                obs_busy_after = busy;
                break;
            end
        end
        if (obs_done_at == 0) obs_timeout = 1'b1;
        req = 1'b0;
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({busy, done, misalign, mem_req, mem_we} !== 5'b00000) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, misalign, mem_req, mem_we});
        end
        checks++;
        if (mem_waddr !== 30'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0 || rdata !== 32'h0) begin
            errors++; $display("FAIL reset_data: got waddr=%h be=%h wdata=%h rdata=%h expected all 0",
                               mem_waddr, mem_be, mem_wdata, rdata);
        end
        rst = 1'b0;
        $display("reset: busy=%b mem_req=%b rdata=%h", busy, mem_req, rdata);
    endtask

    task automatic test_word_load();
        run_access(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 2, 32'h1234_5678, 1'b0);
        $display("word load 0x100: req_cycles=%0d done_at=%0d rdata=%h", obs_req_cycles, obs_done_at, obs_rdata);
        checks++;
        if (obs_timeout) begin errors++; $display("FAIL word_timeout: got no done expected done"); end
        checks++;
        if (obs_waddr !== 30'h40 || obs_be !== 4'b1111 || obs_we !== 1'b0) begin
            errors++; $display("FAIL word_addr: got waddr=%h be=%b we=%b expected 40 1111 0", obs_waddr, obs_be, obs_we);
        end
        checks++;
        if (obs_req_cycles !== 3 || obs_done_at !== 4) begin
            errors++; $display("FAIL word_latency: got req_cycles=%0d done_at=%0d expected 3 4", obs_req_cycles, obs_done_at);
        end
        checks++;
        if (obs_rdata !== 32'h1234_5678) begin
            errors++; $display("FAIL word_rdata: got %h expected 12345678", obs_rdata);
        end
        checks++;
        if (obs_done_cycles !== 1 || obs_mis_cycles !== 0 || obs_busy_after !== 1'b0 || obs_overlap || obs_unstable) begin
            errors++; $display("FAIL word_handshake: got done=%0d mis=%0d busy_after=%b overlap=%b unstable=%b expected 1 0 0 0 0",
                               obs_done_cycles, obs_mis_cycles, obs_busy_after, obs_overlap, obs_unstable);
        end
    endtask

    task automatic test_byte_load();
        run_access(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 1, 32'h80AA_BBCC, 1'b0);
        $display("byte load 0x103 sgn=1: be=%b rdata=%h", obs_be, obs_rdata);
        checks++;
        if (obs_be !== 4'b1000 || obs_rdata !== 32'hFFFF_FF80) begin
            errors++; $display("FAIL byte_sext: got be=%b rdata=%h expected 1000 ffffff80", obs_be, obs_rdata);
        end
        run_access(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 0, 32'h80AA_BBCC, 1'b0);
        $display("byte load 0x103 sgn=0: done_at=%0d rdata=%h", obs_done_at, obs_rdata);
        checks++;
        if (obs_rdata !== 32'h0000_0080 || obs_done_at !== 2) begin
            errors++; $display("FAIL byte_zext: got rdata=%h done_at=%0d expected 00000080 2", obs_rdata, obs_done_at);
        end
        run_access(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 1, 32'h80AA_BBCC, 1'b0);
        $display("half load 0x102 sgn=1: be=%b rdata=%h", obs_be, obs_rdata);
        checks++;
        if (obs_be !== 4'b1100 || obs_rdata !== 32'hFFFF_80AA) begin
            errors++; $display("FAIL half_sext: got be=%b rdata=%h expected 1100 ffff80aa", obs_be, obs_rdata);
        end
        run_access(1'b0, 2'b00, 1'b1, 32'h0000_0101, 32'h0, 0, 32'h80AA_BBCC, 1'b0);
        $display("byte load 0x101 sgn=1: be=%b rdata=%h", obs_be, obs_rdata);
        checks++;
        if (obs_be !== 4'b0010 || obs_rdata !== 32'hFFFF_FFBB) begin
            errors++; $display("FAIL byte_lane1: got be=%b rdata=%h expected 0010 ffffffbb", obs_be, obs_rdata);
        end
    endtask

    task automatic test_stores();
        run_access(1'b1, 2'b01, 1'b0, 32'h0000_0002, 32'h0000_BEEF, 1, 32'h5555_5555, 1'b0);
        $display("half store 0x2: waddr=%h be=%b we=%b wdata=%h", obs_waddr, obs_be, obs_we, obs_wdata);
        checks++;
        if (obs_waddr !== 30'h0 || obs_be !== 4'b1100 || obs_we !== 1'b1 || obs_wdata !== 32'hBEEF_BEEF) begin
            errors++; $display("FAIL half_store: got waddr=%h be=%b we=%b wdata=%h expected 0 1100 1 beefbeef",
                               obs_waddr, obs_be, obs_we, obs_wdata);
        end
        checks++;
        if (obs_timeout || obs_rdata !== 32'hFFFF_FFBB) begin
            errors++; $display("FAIL store_rdata: got rdata=%h timeout=%b expected ffffffbb 0", obs_rdata, obs_timeout);
        end
        run_access(1'b1, 2'b00, 1'b0, 32'h0000_1001, 32'h1234_56A5, 0, 32'h0, 1'b0);
        $display("byte store 0x1001: waddr=%h be=%b wdata=%h", obs_waddr, obs_be, obs_wdata);
        checks++;
        if (obs_waddr !== 30'h400 || obs_be !== 4'b0010 || obs_wdata !== 32'hA5A5_A5A5) begin
            errors++; $display("FAIL byte_store: got waddr=%h be=%b wdata=%h expected 400 0010 a5a5a5a5",
                               obs_waddr, obs_be, obs_wdata);
        end
    endtask

    task automatic test_misalign();
        logic [1:0]  sz_tab [3] = '{2'b01, 2'b11, 2'b10};
        logic [31:0] a_tab  [3] = '{32'h1, 32'h0, 32'h2};
        for (int i = 0; i < 3; i++) begin
            run_access(1'b0, sz_tab[i], 1'b1, a_tab[i], 32'h0, 0, 32'h0000_0000, 1'b0);
            $display("misaligned size=%b addr=%h: req_cycles=%0d done=%0d mis=%0d rdata=%h",
                     sz_tab[i], a_tab[i], obs_req_cycles, obs_done_cycles, obs_mis_cycles, obs_rdata);
            checks++;
            if (obs_req_cycles !== 0 || obs_done_cycles !== 1 || obs_mis_cycles !== 1 || obs_done_at !== 1) begin
                errors++; $display("FAIL misalign_%0d: got req=%0d done=%0d mis=%0d done_at=%0d expected 0 1 1 1",
                                   i, obs_req_cycles, obs_done_cycles, obs_mis_cycles, obs_done_at);
            end
            checks++;
            if (obs_rdata !== 32'hFFFF_FFBB || obs_busy_after !== 1'b0) begin
                errors++; $display("FAIL misalign_rdata_%0d: got rdata=%h busy_after=%b expected ffffffbb 0",
                                   i, obs_rdata, obs_busy_after);
            end
        end
    endtask

    task automatic test_req_ignored();
        run_access(1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0, 2, 32'hCAFE_F00D, 1'b1);
        $display("req during access: waddr=%h req_cycles=%0d rdata=%h busy_after=%b",
                 obs_waddr, obs_req_cycles, obs_rdata, obs_busy_after);
        checks++;
        if (obs_waddr !== 30'h80 || obs_unstable || obs_req_cycles !== 3) begin
            errors++; $display("FAIL ignore_addr: got waddr=%h unstable=%b req_cycles=%0d expected 80 0 3",
                               obs_waddr, obs_unstable, obs_req_cycles);
        end
        checks++;
        if (obs_rdata !== 32'hCAFE_F00D || obs_busy_after !== 1'b0 || obs_done_cycles !== 1) begin
            errors++; $display("FAIL ignore_result: got rdata=%h busy_after=%b done=%0d expected cafef00d 0 1",
                               obs_rdata, obs_busy_after, obs_done_cycles);
        end
    endtask

    task automatic test_reset_mid_access();
        int done_seen;
        done_seen = 0;
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b10; sgn = 1'b0; baddr = 32'h0000_0300;
        @(negedge clk);
        req = 1'b0;
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_pre: got mem_req=%b expected 1", mem_req); end
        rst = 1'b1;
        #1;
        $display("reset mid-access: mem_req=%b busy=%b", mem_req, busy);
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || rdata !== 32'h0) begin
            errors++; $display("FAIL rst_drop: got mem_req=%b busy=%b rdata=%h expected 0 0 0", mem_req, busy, rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'h1111_2222;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (done || busy || mem_req) done_seen++;
        end
        $display("late ack after reset: activity_cycles=%0d rdata=%h", done_seen, rdata);
        checks++;
        if (done_seen !== 0 || rdata !== 32'h0) begin
            errors++; $display("FAIL rst_late_ack: got activity=%0d rdata=%h expected 0 0", done_seen, rdata);
        end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_load();
        test_stores();
        test_misalign();
        test_req_ignored();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
